// File: rtl/vad_frame_packer.sv
// Ping-pong frame packer: assembles FEAT_NUM-word frames from a serial stream and hands them to `top`.
// Optional macro VAD_PACK_DROP_EN: never backpressure; overwrite the oldest unread frame instead.
module vad_frame_packer #(
    parameter int FEAT_NUM = 20,
    parameter int DATA_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    input  logic [DATA_W-1:0]            s_data,
    output logic                         s_ready,
    input  logic                         frame_req,
    output logic                         read_en,
    output logic [FEAT_NUM*DATA_W-1:0]   frame_data,
    output logic [7:0]                   drop_cnt
);

    localparam int IDX_W = (FEAT_NUM > 1) ? $clog2(FEAT_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DELIVER,
        HOLD
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             full, full_nxt;
    logic                   wr_sel;
    logic                   rd_sel;
    logic                   hold_cnt;
    logic [IDX_W-1:0]       wr_idx;
    logic [DATA_W-1:0]      mem [2][FEAT_NUM];

    logic                   accept;
    logic                   fill_done;
    logic                   deliver;
    logic                   drop;
    logic                   readable;

    assign accept    = s_valid && s_ready;
    assign fill_done = accept && (wr_idx == IDX_W'(FEAT_NUM - 1));
    assign deliver   = (state == DELIVER);

`ifdef VAD_PACK_DROP_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] drop_q;

    assign s_ready  = 1'b1;
    // A buffer being freed by DELIVER this cycle is not an overwrite.
    assign drop     = accept && (wr_idx == '0) && full[wr_sel] && !(deliver && (rd_sel == wr_sel));
    assign drop_cnt = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (drop) begin
            drop_q <= sat_inc(drop_q);
        end
    end
`else
    assign s_ready  = !full[wr_sel];
    assign drop     = 1'b0;
    assign drop_cnt = 8'd0;
`endif

    // In overwrite mode the oldest buffer may be the one currently being refilled.
    assign readable = full[rd_sel] && !((rd_sel == wr_sel) && (wr_idx != '0));

    always_comb begin
        full_nxt = full;
        if (deliver) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (fill_done) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (frame_req && readable) state_nxt = DELIVER;
            DELIVER: state_nxt = HOLD;
            HOLD:    if (!frame_req || hold_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            full       <= 2'b00;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            wr_idx     <= '0;
            hold_cnt   <= 1'b0;
            read_en    <= 1'b0;
            frame_data <= '0;
        end else begin
            state    <= state_nxt;
            full     <= full_nxt;
            hold_cnt <= (state == HOLD);
            read_en  <= deliver;
            rd_sel   <= rd_sel ^ deliver ^ drop;
            if (accept) begin
                if (fill_done) begin
                    wr_idx <= '0;
                    wr_sel <= !wr_sel;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (deliver) begin
                for (int k = 0; k < FEAT_NUM; k++) begin
                    frame_data[k*DATA_W +: DATA_W] <= mem[rd_sel][k];
                end
            end
        end
    end

    // Frame storage carries no reset; the full flags say what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_sel][wr_idx] <= s_data;
        end
    end

endmodule

// File: tb/tb_vad_frame_packer.sv
// Directed self-checking bench for vad_frame_packer (works with or without VAD_PACK_DROP_EN).
module tb_vad_frame_packer;

    localparam int FEAT_NUM = 20;
    localparam int DATA_W   = 16;

    logic                       clk;
    logic                       rst_n;
    logic                       s_valid;
    logic [DATA_W-1:0]          s_data;
    logic                       s_ready;
    logic                       frame_req;
    logic                       read_en;
    logic [FEAT_NUM*DATA_W-1:0] frame_data;
    logic [7:0]                 drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] first;
        logic [15:0] last;
        bit          uniform;
    } dlv_t;

    dlv_t dq[$];

    vad_frame_packer #(.FEAT_NUM(FEAT_NUM), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .frame_req  (frame_req),
        .read_en    (read_en),
        .frame_data (frame_data),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Delivery monitor: records each frame and checks strobe width and spacing.
    logic prev_re  = 1'b0;
    int   last_dlv = -100;
    always @(negedge clk) begin
        if (read_en) begin
            dlv_t d;
            chk("read_en_width", {31'd0, prev_re}, 32'd1 - 32'd1);
            chk("read_en_gap", {31'd0, (cyc - last_dlv) >= 2}, 32'd1);
            last_dlv  = cyc;
            d.first   = frame_data[15:0];
            d.last    = frame_data[FEAT_NUM*DATA_W-1 -: DATA_W];
            d.uniform = 1'b1;
            for (int k = 0; k < FEAT_NUM; k++) begin
                if (frame_data[k*DATA_W +: DATA_W] != d.first) d.uniform = 1'b0;
            end
            dq.push_back(d);
        end
        prev_re = read_en;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        frame_req = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        dq.delete();
    endtask

    // Leaves s_valid high on return so consecutive words stream at full rate.
    task automatic feed_word(input logic [DATA_W-1:0] v);
        int n;
        s_valid = 1'b1;
        s_data  = v;
        n = 0;
        while (!s_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk("feed_timeout", 32'd0, 32'd1);
        tick(1);
    endtask

    task automatic feed_frame(input logic [DATA_W-1:0] v);
        for (int i = 0; i < FEAT_NUM; i++) feed_word(v);
        s_valid = 1'b0;
    endtask

    initial begin
        apply_reset();

        // Reset values
        chk("rst_read_en", {31'd0, read_en}, 32'd0);
        chk("rst_frame_data_nz", {31'd0, |frame_data}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // Words 1..20 with frame_req high: strobe two edges after word 20
        frame_req = 1'b1;
        for (int i = 1; i <= FEAT_NUM; i++) feed_word(DATA_W'(i));
        s_valid = 1'b0;
        chk("t1_re_n0", {31'd0, read_en}, 32'd0);
        tick(1);
        chk("t1_re_n1", {31'd0, read_en}, 32'd0);
        tick(1);
        chk("t1_re_n2", {31'd0, read_en}, 32'd1);
        chk("t1_word0", {16'd0, frame_data[15:0]}, 32'd1);
        chk("t1_word9", {16'd0, frame_data[9*DATA_W +: DATA_W]}, 32'd10);
        chk("t1_word19", {16'd0, frame_data[319:304]}, 32'd20);
        tick(1);
        chk("t1_re_n3", {31'd0, read_en}, 32'd0);
        chk("t1_hold_word19", {16'd0, frame_data[319:304]}, 32'd20);
        tick(5);
        frame_req = 1'b0;
        tick(3);
        chk("t1_count", dq.size(), 32'd1);

        // Three frames 2s,3s,4s buffered with no request
        apply_reset();
        feed_frame(16'd2);
        feed_frame(16'd3);
`ifdef VAD_PACK_DROP_EN
        chk("t2_s_ready", {31'd0, s_ready}, 32'd1);
        feed_frame(16'd4);
        chk("t2_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        frame_req = 1'b1;
        tick(30);
        frame_req = 1'b0;
        tick(3);
        chk("t2_count", dq.size(), 32'd2);
        if (dq.size() >= 2) begin
            chk("t2_first", {16'd0, dq[0].first}, 32'd3);
            chk("t2_second", {16'd0, dq[1].first}, 32'd4);
            chk("t2_uniform", {31'd0, dq[0].uniform && dq[1].uniform}, 32'd1);
        end
`else
        chk("t2_s_ready", {31'd0, s_ready}, 32'd0);
        fork
            feed_frame(16'd4);
            begin
                tick(2);
                frame_req = 1'b1;
            end
        join
        tick(30);
        frame_req = 1'b0;
        tick(3);
        chk("t2_count_ge2", {31'd0, dq.size() >= 2}, 32'd1);
        if (dq.size() >= 2) begin
            chk("t2_first", {16'd0, dq[0].first}, 32'd2);
            chk("t2_second", {16'd0, dq[1].first}, 32'd3);
            chk("t2_uniform", {31'd0, dq[0].uniform && dq[1].uniform}, 32'd1);
        end
        chk("t2_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif

        // Six back-to-back frames with frame_req held high
        apply_reset();
        frame_req = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            for (int i = 0; i < FEAT_NUM; i++) feed_word(DATA_W'(f));
        end
        s_valid = 1'b0;
        tick(10);
        frame_req = 1'b0;
        tick(3);
        chk("t3_count", dq.size(), 32'd6);
        for (int i = 0; i < dq.size(); i++) begin
            chk($sformatf("t3_order%0d", i), {16'd0, dq[i].first}, i + 1);
            chk($sformatf("t3_uniform%0d", i), {31'd0, dq[i].uniform}, 32'd1);
        end

        // Reset mid-frame discards the partial frame
        apply_reset();
        frame_req = 1'b1;
        for (int i = 0; i < 10; i++) feed_word(16'd9);
        apply_reset();
        frame_req = 1'b1;
        feed_frame(16'd7);
        tick(20);
        frame_req = 1'b0;
        tick(3);
        chk("t4_count", dq.size(), 32'd1);
        if (dq.size() >= 1) begin
            chk("t4_value", {16'd0, dq[0].first}, 32'd7);
            chk("t4_uniform", {31'd0, dq[0].uniform}, 32'd1);
        end

        // Fill of B1 completes on the same edge DELIVER clears B0
        apply_reset();
        feed_frame(16'd5);
        for (int i = 0; i < FEAT_NUM - 1; i++) feed_word(16'd6);
        s_valid   = 1'b0;
        frame_req = 1'b1;
        tick(1);
        s_valid = 1'b1;
        s_data  = 16'd6;
        tick(1);
        s_valid = 1'b0;
        chk("t5_re", {31'd0, read_en}, 32'd1);
        chk("t5_word0", {16'd0, frame_data[15:0]}, 32'd5);
        chk("t5_word19", {16'd0, frame_data[319:304]}, 32'd5);
        tick(10);
        frame_req = 1'b0;
        tick(3);
        chk("t5_count", dq.size(), 32'd2);
        if (dq.size() >= 2) begin
            chk("t5_second", {16'd0, dq[1].first}, 32'd6);
            chk("t5_uniform", {31'd0, dq[1].uniform}, 32'd1);
        end
        chk("t5_s_ready", {31'd0, s_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vad_frame_packer.md
# vad_frame_packer

Upstream feeder for the VAD `top` core. Accepts one 16-bit feature word per handshake from the feature extractor and assembles 20-word frames in a ping-pong buffer. When `top` signals `empty`, it delivers one complete frame as a flat bus together with a one-cycle `read_en` strobe. This decouples the serial feature stream from the frame-parallel BNN input.

## Interface
- `FEAT_NUM`, 20: words per frame.
- `DATA_W`, 16: bits per word.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  input word valid.
- `s_data`  in  DATA_W  input feature word.
- `s_ready`  out  1  packer can accept a word.
- `frame_req`  in  1  connects to `top.empty`; high means `top` wants a frame.
- `read_en`  out  1  frame-delivery strobe to `top.read_en`.
- `frame_data`  out  FEAT_NUM*DATA_W  delivered frame; word k at bits [k*DATA_W +: DATA_W], maps to `data_in[k+1]`.
- `drop_cnt`  out  8  dropped-frame count, saturating at 255.

## Operation
- Two buffers, B0 and B1, each FEAT_NUM x DATA_W, with per-buffer `full` flags.
- `wr_sel` names the buffer being filled; `wr_idx` runs 0..FEAT_NUM-1.
- A word is accepted when `s_valid && s_ready`. It is written at `wr_idx`, then `wr_idx` increments.
- At `wr_idx == FEAT_NUM-1`, an accepted word:
  - sets `full[wr_sel]`,
  - wraps `wr_idx` to 0,
  - toggles `wr_sel`.
- Read FSM states:
  - IDLE: if `frame_req` and a full buffer exists, go to DELIVER. Buffers are served in fill order; `rd_sel` tracks the oldest.
  - DELIVER: one cycle. `read_en`=1, `frame_data` loaded from `rd_sel`, `full[rd_sel]` cleared, `rd_sel` toggled. Go to HOLD.
  - HOLD: return to IDLE once `frame_req` is low. If `frame_req` stays high for 2 cycles after DELIVER, return to IDLE anyway. This covers `top` holding `empty` high.
- `frame_data` is a register. It changes only on the DELIVER cycle and holds its value otherwise.
- If a frame completes in the same cycle a read is requested, it becomes readable the next cycle. No bypass.
- If a fill completes on the same cycle DELIVER clears the other buffer, both updates apply.
- Reset values:
  - outputs: `read_en`=0, `frame_data`=0, `s_ready`=1, `drop_cnt`=0;
  - internal: both `full`=0, `wr_idx`=0, `wr_sel`=B0, `rd_sel`=B0, FSM in IDLE.
- Reset mid-frame discards the partial frame and any unread full frames.

## Timing
- `read_en` rises on the first rising edge after `frame_req`=1 is sampled while a full buffer exists (1-cycle latency).
- `read_en` is high for exactly 1 cycle.
- `frame_data` is valid in the same cycle as `read_en` and stable afterwards.
- Minimum spacing between `read_en` strobes is 2 cycles.
- Input throughput is 1 word/cycle while `s_ready`=1.
- Best-case frame latency: last word accepted at edge N, `read_en` at edge N+2 if `frame_req` is already high.
- `s_ready` is combinational: `!(full[wr_sel])`, or constant 1 with the drop option (see Configuration).

## Configuration
- Macro: `VAD_PACK_DROP_EN`.
- Defined:
  - `s_ready` is tied to 1.
  - If the fill buffer is still full when its first word arrives, the oldest unread frame is overwritten.
  - The `full` flag stays set, `rd_sel` advances to the other buffer, and `drop_cnt` increments, saturating at 255.
- Undefined:
  - Backpressure mode: `s_ready`=0 while `full[wr_sel]`; no words are lost.
  - `drop_cnt` is tied to 0.

## Test plan
- Reset, then feed words 1..20 with `s_valid` continuous and `frame_req`=1 → single `read_en` 2 cycles after word 20; `frame_data[15:0]`=1, `[319:304]`=20.
- Feed 3 frames (all 2s, 3s, 4s) with `frame_req`=0, then raise `frame_req` → without macro, `s_ready` drops after frame 2 and the frames delivered are 2s then 3s.
- Same as the previous test with `VAD_PACK_DROP_EN` → `s_ready` stays 1, delivered frames are 3s then 4s, `drop_cnt`=1.
- Hold `frame_req`=1 continuously across 6 back-to-back frames → 6 `read_en` pulses, each 1 cycle wide and ≥2 cycles apart, in order 1..6.
- Assert `rst_n`=0 after 10 words, release, feed 20 words of 7 → exactly one delivered frame, all 7s.
- Complete a frame on the same edge as DELIVER of the other buffer → both `full` updates are correct and the next request delivers the new frame.
